aes_stream_engine: RTL and testbench
====================================

// Module: aes_stream_engine
// PURPOSE
//  Sequential streaming wrapper around the combinational AES128 core (Input, CipherKey, inv, Output).
//  Adds valid/ready handshakes, key/IV registers, ECB or CBC chaining, message framing and an output FIFO.
//  Sits between a block source (file reader / DMA) and a block sink; replaces direct per-clock core driving.
// PARAMETERS
//  FIFO_DEPTH  4   output FIFO depth in 128-bit blocks, power of two, >=2
//  CBC_EN      1   1: CBC mode selectable via cfg_cbc; 0: cfg_cbc ignored, ECB only
//  CNT_W       32  width of blk_count
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  key_load   in   1          load key_in into key register (honoured only in IDLE)
//  key_in     in   128        cipher key
//  iv_load    in   1          load iv_in into IV register (honoured only in IDLE)
//  iv_in      in   128        CBC initialisation vector
//  cfg_inv    in   1          0 encrypt, 1 decrypt; sampled on first block of a message
//  cfg_cbc    in   1          0 ECB, 1 CBC; sampled on first block of a message
//  in_valid   in   1          input block valid
//  in_ready   out  1          engine can accept a block
//  in_data    in   128        input block, byte 0 in [127:120]
//  in_last    in   1          final block of current message
//  out_valid  out  1          out_data valid (FIFO non-empty)
//  out_ready  in   1          sink accepts out_data
//  out_data   out  128        result block
//  out_last   out  1          result belongs to final block of message
//  busy       out  1          state RUN or FIFO non-empty
//  cfg_err    out  1          one-cycle pulse: key_load/iv_load requested in RUN (ignored)
//  blk_count  out  CNT_W      blocks accepted since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: key, IV, chain regs = 0; state IDLE; FIFO empty; out_valid=0, out_data=0, out_last=0,
//   in_ready=0 during reset, busy=0, cfg_err=0, blk_count=0. Reset mid-message discards everything.
//  FSM: IDLE -> RUN on accepted block with in_last=0; RUN -> IDLE on accepted block with in_last=1.
//   Accepted block in IDLE with in_last=1: single-block message, stays IDLE.
//  Mode: on accept in IDLE latch inv_q=cfg_inv, cbc_q=cfg_cbc&CBC_EN, chain<=IV reg; held until IDLE.
//  Datapath (accept = in_valid & in_ready), chain = chain reg or IV reg on first block:
//   ECB:       core_in=in_data;         result=core_out
//   CBC enc:   core_in=in_data^chain;   result=core_out;        chain<=result
//   CBC dec:   core_in=in_data;         result=core_out^chain;  chain<=in_data
//  Core inputs are combinational from in_data; result written to FIFO on accept edge.
//  Latency: block accepted at edge N is at FIFO head; out_valid=1 after edge N if FIFO was empty.
//  in_ready = (FIFO count < FIFO_DEPTH) & ~(IDLE & (key_load|iv_load)); no out_ready->in_ready path.
//  Full: no accept, in_data ignored. Push and pop same cycle when full: pop only (in_ready was 0).
//  Empty: out_valid=0, out_data holds last value. Push+pop same cycle at count=1: count stays 1.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  key_load and iv_load both in IDLE: both load same edge. In RUN: ignored, cfg_err pulses 1 cycle.
//  Key register change never affects a message in progress.
// TESTING
//  1 ECB enc, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, last=1
//    -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, one cycle after accept.
//  2 ECB dec of 69c4e0d8... with same key -> 00112233445566778899aabbccddeeff.
//  3 CBC enc, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102...0f, pt 6bc1bee22e409f96e93d7e117393172a,
//    ae2d8a571e03ac9c9eb76fac45af8e51(last) -> 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2.
//  4 CBC dec of the two ciphertexts of 3 -> original plaintexts; second message restarts from IV.
//  5 out_ready=0, push 5 blocks with FIFO_DEPTH=4 -> in_ready=0 after 4th; release -> 5 blocks in order.
//  6 key_load in RUN -> cfg_err pulse, outputs unchanged; rst_n low mid-message -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/aes_stream_engine.sv
// rtl/aes_stream_engine.sv - Streaming AES-128 engine with ECB/CBC chaining and output FIFO
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   key_load/key_in         key register load (IDLE only)
//   iv_load/iv_in           IV register load (IDLE only)
//   cfg_inv, cfg_cbc        direction / chaining, sampled on the first block of a message
//   in_valid/in_ready/in_data/in_last     block input handshake
//   out_valid/out_ready/out_data/out_last result output from FIFO head
//   busy, cfg_err, blk_count              status
module aes_stream_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter bit CBC_EN     = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [127:0]     key_in,
    input  logic             iv_load,
    input  logic [127:0]     iv_in,
    input  logic             cfg_inv,
    input  logic             cfg_cbc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             busy,
    output logic             cfg_err,
    output logic [CNT_W-1:0] blk_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // GF(2^8) arithmetic; the S-box is derived from the field inverse instead of a table.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic inverse);
        logic [7:0] x;
        if (inverse) begin
            x = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
            return ginv(x);
        end
        x = ginv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    // State byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] subBytes(input logic [127:0] s, input logic inverse);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8], inverse);
        return o;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inverse);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inverse ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    // Row r of the output column uses the coefficient vector rotated by r.
    function automatic logic [127:0] mixColumns(input logic [127:0] s, input logic inverse);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        coef = inverse ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-8*(((r+k)%4)+4*c) -: 8], coef[k]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [10:0][127:0] expandKey(input logic [127:0] key);
        logic [31:0]       w [44];
        logic [31:0]       t;
        logic [7:0]        rcon = 8'h01;
        logic [10:0][127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16], 1'b0), sbox(t[15:8], 1'b0), sbox(t[7:0], 1'b0), sbox(t[31:24], 1'b0)}
                    ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    typedef enum logic {IDLE, RUN} stateT;

    stateT              stateQ, stateD;
    logic [127:0]       keyQ, ivQ, chainQ;
    logic               invQ, cbcQ;
    logic [128:0]       fifoMem [FIFO_DEPTH];
    logic [128:0]       holdQ;
    logic [AW-1:0]      wrPtr, rdPtr;
    logic [AW:0]        countQ;
    logic               cfgErrQ;
    logic [CNT_W-1:0]   blkCountQ;
    logic               isIdle, cfgReq, accept, pop;
    logic               modeInv, modeCbc;
    logic [127:0]       chainSel, coreIn, coreOut, result;
    logic [10:0][127:0] roundKeys;

    assign isIdle = (stateQ == IDLE);
    assign cfgReq = key_load | iv_load;
    // Gated by rst_n so the source sees no room while reset is held.
    assign in_ready = rst_n & (countQ < (AW+1)'(FIFO_DEPTH)) & ~(isIdle & cfgReq);
    assign accept = in_valid & in_ready;
    assign pop = (countQ != '0) & out_ready;

    // First block of a message takes its mode and chain value straight from the config/IV.
    assign modeInv  = isIdle ? cfg_inv : invQ;
    assign modeCbc  = isIdle ? (cfg_cbc & CBC_EN) : cbcQ;
    assign chainSel = isIdle ? ivQ : chainQ;
    assign coreIn   = (modeCbc & ~modeInv) ? (in_data ^ chainSel) : in_data;
    assign result   = (modeCbc & modeInv) ? (coreOut ^ chainSel) : coreOut;
    assign roundKeys = expandKey(keyQ);

    always_comb begin
        coreOut = '0;
        if (!modeInv) begin
            coreOut = coreIn ^ roundKeys[0];
            for (int r = 1; r < 10; r++)
                coreOut = mixColumns(shiftRows(subBytes(coreOut, 1'b0), 1'b0), 1'b0) ^ roundKeys[r];
            coreOut = shiftRows(subBytes(coreOut, 1'b0), 1'b0) ^ roundKeys[10];
        end else begin
            coreOut = coreIn ^ roundKeys[10];
            for (int r = 9; r > 0; r--)
                coreOut = mixColumns(subBytes(shiftRows(coreOut, 1'b1), 1'b1) ^ roundKeys[r], 1'b1);
            coreOut = subBytes(shiftRows(coreOut, 1'b1), 1'b1) ^ roundKeys[0];
        end
    end

    always_comb begin
        stateD = stateQ;
        if (accept) stateD = in_last ? IDLE : RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            keyQ      <= '0;
            ivQ       <= '0;
            chainQ    <= '0;
            invQ      <= 1'b0;
            cbcQ      <= 1'b0;
            holdQ     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            countQ    <= '0;
            cfgErrQ   <= 1'b0;
            blkCountQ <= '0;
        end else begin
            stateQ  <= stateD;
            cfgErrQ <= ~isIdle & cfgReq;
            if (isIdle & key_load) keyQ <= key_in;
            if (isIdle & iv_load) ivQ <= iv_in;
            if (accept) begin
                if (isIdle) begin
                    invQ <= cfg_inv;
                    cbcQ <= cfg_cbc & CBC_EN;
                end
                // Encrypt chains on the ciphertext produced, decrypt on the ciphertext consumed.
                chainQ    <= modeCbc ? (modeInv ? in_data : result) : chainSel;
                wrPtr     <= wrPtr + 1'b1;
                blkCountQ <= blkCountQ + 1'b1;
            end
            if (pop) begin
                holdQ <= fifoMem[rdPtr];
                rdPtr <= rdPtr + 1'b1;
            end
            countQ <= countQ + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifoMem[wrPtr] <= {in_last, result};
    end

    // When empty the last popped block stays visible on out_data.
    assign out_valid = (countQ != '0);
    assign {out_last, out_data} = out_valid ? fifoMem[rdPtr] : holdQ;
    assign busy      = ~isIdle | out_valid;
    assign cfg_err   = cfgErrQ;
    assign blk_count = blkCountQ;
endmodule

// File: tb/tb_aes_stream_engine.sv
// tb/tb_aes_stream_engine.sv - Self-checking bench for aes_stream_engine
module tb_aes_stream_engine;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PB  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CA  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CB  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] EA  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] EB  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] EZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0, iv_load = 1'b0, cfg_inv = 1'b0, cfg_cbc = 1'b0;
    logic [127:0] key_in = '0, iv_in = '0, in_data = '0;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, out_last, busy, cfg_err;
    logic [127:0] out_data;
    logic [31:0]  blk_count;

    aes_stream_engine #(.FIFO_DEPTH(4), .CBC_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .iv_load(iv_load), .iv_in(iv_in), .cfg_inv(cfg_inv), .cfg_cbc(cfg_cbc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .cfg_err(cfg_err), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] iv;
        logic         inv;
        logic         cbc;
        logic [127:0] din;
        logic         last;
        logic [127:0] dout;
    } vecT;

    int           checkCount = 0;
    int           passCount = 0;
    int           expCount = 0;
    logic [128:0] expQ [$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("FAIL out_unexpected: got %h with nothing expected", {out_last, out_data});
            end else begin
                check("out_block", {out_last, out_data}, expQ.pop_front());
            end
        end
    end

    task automatic stepTo();
        @(posedge clk);
        #1;
    endtask

    task automatic loadCfg(input logic [127:0] k, input logic [127:0] v);
        key_in = k; iv_in = v; key_load = 1'b1; iv_load = 1'b1;
        @(negedge clk);
        check("in_ready_during_cfg_load", in_ready, 0);
        stepTo();
        key_load = 1'b0; iv_load = 1'b0;
    endtask

    task automatic sendBlock(input logic [127:0] d, input logic l, input logic [127:0] e, input logic el);
        bit done = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (done) begin
            @(posedge clk);
            expQ.push_back({el, e});
            expCount++;
        end else begin
            checkCount++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && expQ.size() != 0; n++) @(negedge clk);
        if (expQ.size() != 0) begin
            checkCount++;
            $display("FAIL drain_timeout: %0d blocks outstanding expected 0", expQ.size());
        end
        stepTo();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_blk_count"}, blk_count, 0);
    endtask

    vecT vecs [11];
    bit  firstOfMsg;

    initial begin
        vecs[0]  = '{K1, IV, 1'b0, 1'b0, P1, 1'b1, C1};
        vecs[1]  = '{K1, IV, 1'b1, 1'b0, C1, 1'b1, P1};
        vecs[2]  = '{K2, IV, 1'b0, 1'b1, PA, 1'b0, CA};
        vecs[3]  = '{K2, IV, 1'b0, 1'b1, PB, 1'b1, CB};
        vecs[4]  = '{K2, IV, 1'b1, 1'b1, CA, 1'b0, PA};
        vecs[5]  = '{K2, IV, 1'b1, 1'b1, CB, 1'b1, PB};
        vecs[6]  = '{K2, IV, 1'b1, 1'b1, CA, 1'b1, PA};
        vecs[7]  = '{K2, IV, 1'b0, 1'b0, PA, 1'b0, EA};
        vecs[8]  = '{K2, IV, 1'b0, 1'b0, PB, 1'b1, EB};
        vecs[9]  = '{K2, IV, 1'b1, 1'b0, EA, 1'b1, PA};
        vecs[10] = '{K2, IV, 1'b0, 1'b1, PA, 1'b1, CA};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        stepTo();
        rst_n = 1'b1;

        // Table-driven vectors, each message loads key and IV first.
        firstOfMsg = 1;
        foreach (vecs[i]) begin
            cfg_inv = vecs[i].inv;
            cfg_cbc = vecs[i].cbc;
            if (firstOfMsg) loadCfg(vecs[i].key, vecs[i].iv);
            sendBlock(vecs[i].din, vecs[i].last, vecs[i].dout, vecs[i].last);
            firstOfMsg = vecs[i].last;
        end
        drain();
        check("table_busy_idle", busy, 0);
        check("table_blk_count", blk_count, expCount);

        // FIFO fill with sink stalled, then release.
        cfg_inv = 1'b0; cfg_cbc = 1'b0;
        loadCfg(K2, IV);
        out_ready = 1'b0;
        sendBlock(PA, 1'b0, EA, 1'b0);
        @(negedge clk);
        check("latency_out_valid", out_valid, 1);
        check("latency_out_data", out_data, EA);
        stepTo();
        sendBlock(PB, 1'b0, EB, 1'b0);
        sendBlock(PA, 1'b0, EA, 1'b0);
        sendBlock(PB, 1'b0, EB, 1'b0);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        stepTo();
        in_valid = 1'b1; in_data = PA; in_last = 1'b1;
        repeat (3) @(negedge clk);
        check("full_no_accept", blk_count, expCount);
        check("full_in_ready_held", in_ready, 0);
        stepTo();
        out_ready = 1'b1;
        sendBlock(PA, 1'b1, EA, 1'b1);
        drain();
        @(negedge clk);
        check("empty_out_valid", out_valid, 0);
        check("empty_hold_data", {out_last, out_data}, {1'b1, EA});
        stepTo();

        // key_load during a message is refused and flagged.
        loadCfg(K2, IV);
        sendBlock(PA, 1'b0, EA, 1'b0);
        key_load = 1'b1; key_in = K1;
        @(negedge clk);
        check("run_in_ready", in_ready, 1);
        check("run_busy", busy, 1);
        stepTo();
        key_load = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        stepTo();
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 0);
        stepTo();
        sendBlock(PB, 1'b1, EB, 1'b1);
        drain();

        // Reset in the middle of a message.
        out_ready = 1'b0;
        loadCfg(K2, IV);
        sendBlock(PA, 1'b0, EA, 1'b0);
        rst_n = 1'b0;
        expQ.delete();
        expCount = 0;
        #2;
        checkResetOutputs("midreset");
        stepTo();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cfg_inv = 1'b0; cfg_cbc = 1'b0;
        sendBlock(128'h0, 1'b1, EZ, 1'b1);
        drain();
        check("postreset_busy", busy, 0);
        check("postreset_blk_count", blk_count, expCount);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
